// File: rtl/usart_tx_frame.sv
// ---------------------------------------------------------------------------
// usart_tx_frame
//
// Purpose:
//   Parametrised asynchronous serial transmitter. It accepts one character
//   per valid/ready handshake and sends a frame on tx in this order:
//     - a start bit (0)
//     - DATA_BIT data bits, LSB first
//     - an optional parity bit
//     - STOP_BIT stop bits (1)
//   Each bit lasts exactly C = CLK_FREQ/BAUD_RATE clocks. A one-cycle done
//   pulse marks the end of the last stop bit.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line rate in bit/s (C = CLK_FREQ/BAUD_RATE, C >= 2)
//   DATA_BIT   data bits per frame, 5..9
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BIT   stop bits per frame, 1 or 2
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   data   in   character to send, sampled on acceptance only
//   valid  in   producer offers a character
//   ready  out  block accepts a character this cycle (registered)
//   tx     out  serial line, idle high (registered)
//   busy   out  frame in progress (registered)
//   done   out  one-cycle pulse when the last stop bit completes (registered)
// ---------------------------------------------------------------------------
module usart_tx_frame #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BIT  = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BIT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_BIT-1:0] data,
  input  logic                valid,
  output logic                ready,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  // Clocks per bit and the widths of the bit-period and data-bit counters.
  localparam int C  = CLK_FREQ / BAUD_RATE;
  localparam int CW = (C > 2) ? $clog2(C) : 1;
  localparam int BW = $clog2(DATA_BIT + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BIT - 1);

  // Elaboration-time rejection of illegal configurations.
  if (C < 2) begin : g_bad_rate
    $error("usart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((DATA_BIT < 5) || (DATA_BIT > 9)) begin : g_bad_data_bit
    $error("usart_tx_frame: DATA_BIT must be in 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("usart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BIT < 1) || (STOP_BIT > 2)) begin : g_bad_stop_bit
    $error("usart_tx_frame: STOP_BIT must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for a character: even mode makes data+parity carry an even
  // number of ones, odd mode an odd number.
  function automatic logic f_parity(input logic [DATA_BIT-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == 1) begin
      f_parity = ~p;
    end else begin
      f_parity = p;
    end
  endfunction

  state_t              r_state;
  logic [CW-1:0]       r_cnt;      // clocks elapsed in the current bit, 0..C-1
  logic [BW-1:0]       r_bit;      // index of the data bit on the line
  logic                r_stop;     // index of the stop bit on the line
  logic [DATA_BIT-1:0] r_data;     // latched character, source of parity
  logic [DATA_BIT-1:0] r_shift;    // data bits still to send, LSB on the line
  logic                r_tx;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;

  logic                w_bit_end;
  logic                w_par;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_par     = f_parity(r_data);

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

  // Frame sequencer: every output is loaded one bit-boundary ahead so that tx
  // changes exactly on the edge that starts each bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_bit   <= BIT_ZERO;
      r_stop  <= 1'b0;
      r_data  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx    <= 1'b1;
          r_cnt   <= CNT_ZERO;
          r_bit   <= BIT_ZERO;
          r_stop  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          // Accept only while ready is already high, so the idle clock that
          // follows every frame is guaranteed.
          if (valid && r_ready) begin
            r_data  <= data;
            r_shift <= data;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= CNT_ZERO;
            r_bit   <= BIT_ZERO;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= CNT_ZERO;
            if (r_bit == BIT_LAST) begin
              if (PARITY != 0) begin
                r_tx    <= w_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_stop  <= 1'b0;
                r_state <= S_STOP;
              end
            end else begin
              // Next data bit is bit 1 of the shift register before shifting.
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + BIT_ONE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= CNT_ZERO;
            r_tx    <= 1'b1;
            r_stop  <= 1'b0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= CNT_ZERO;
            r_tx  <= 1'b1;
            if (r_stop == STOP_LAST) begin
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_stop <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_usart_tx_frame
//
// Drives three transmitter instances (8N1, 7E2, 7O2, all with 10 clocks per
// bit). Expected line waveforms come from a frame model that lists the frame
// bits from the character and the framing rules. Outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_usart_tx_frame;

  localparam int CF = 1000000;
  localparam int BR = 100000;
  localparam int C  = CF / BR;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] d0    = 8'h00;
  logic [6:0] d1    = 7'h00;
  logic [6:0] d2    = 7'h00;
  logic       valid [3];
  logic       ready [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       done  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  usart_tx_frame #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BIT(8), .PARITY(0), .STOP_BIT(1)) u_dut0 (
    .clk(clk), .reset(reset), .data(d0), .valid(valid[0]),
    .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));

  usart_tx_frame #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BIT(7), .PARITY(2), .STOP_BIT(2)) u_dut1 (
    .clk(clk), .reset(reset), .data(d1), .valid(valid[1]),
    .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));

  usart_tx_frame #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BIT(7), .PARITY(1), .STOP_BIT(2)) u_dut2 (
    .clk(clk), .reset(reset), .data(d2), .valid(valid[2]),
    .ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

  function automatic int db(input int d);
    return (d == 0) ? 8 : 7;
  endfunction

  function automatic int pm(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic int sb(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_data(input int d, input logic [8:0] v);
    case (d)
      0:       d0 = v[7:0];
      1:       d1 = v[6:0];
      default: d2 = v[6:0];
    endcase
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_tx"},    32'(tx[d]),    32'd1);
    chk({tag, "_ready"}, 32'(ready[d]), 32'd1);
    chk({tag, "_busy"},  32'(busy[d]),  32'd0);
    chk({tag, "_done"},  32'(done[d]),  32'd0);
  endtask

  // Sends one character on instance d and checks every clock of the frame.
  // Called on a falling edge. keep: hold valid high and present nxt once the
  // frame starts. pulse_at: frame clock at which valid pulses for one cycle.
  // abort_at: frame clock at which reset is asserted between edges.
  task automatic run_frame(input int d, input logic [8:0] val, input logic [8:0] nxt,
                           input bit keep, input int pulse_at, input int abort_at);
    logic bits [16];
    int   n;
    int   ones;
    n    = 1;
    ones = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < db(d); i++) begin
      bits[n] = val[i];
      ones    = ones + ((val[i] == 1'b1) ? 1 : 0);
      n++;
    end
    if (pm(d) != 0) begin
      bits[n] = (pm(d) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < sb(d); s++) begin
      bits[n] = 1'b1;
      n++;
    end

    chk("ready_before", 32'(ready[d]), 32'd1);
    set_data(d, val);
    valid[d] = 1'b1;
    @(posedge clk);
    for (int j = 0; j < n * C; j++) begin
      @(negedge clk);
      if (j == 0) begin
        if (keep) begin
          set_data(d, nxt);
        end else begin
          valid[d] = 1'b0;
          set_data(d, 9'($urandom));
        end
      end else if (!keep && j == pulse_at) begin
        valid[d] = 1'b1;
      end else if (!keep && j == pulse_at + 1) begin
        valid[d] = 1'b0;
      end
      if (j == abort_at) begin
        #2 reset = 1'b1;
        #1 chk_idle(d, "rst_async");
        @(posedge clk);
        @(negedge clk);
        chk_idle(d, "rst_held");
        #2 reset = 1'b0;
        valid[d] = 1'b0;
        @(negedge clk);
        chk_idle(d, "rst_after");
        return;
      end
      chk("tx_bit",  32'(tx[d]),    32'(bits[j / C]));
      chk("busy",    32'(busy[d]),  32'd1);
      chk("ready_0", 32'(ready[d]), 32'd0);
      chk("done_0",  32'(done[d]),  32'd0);
    end
    @(negedge clk);
    chk("done_end",  32'(done[d]),  32'd1);
    chk("ready_end", 32'(ready[d]), 32'd1);
    chk("busy_end",  32'(busy[d]),  32'd0);
    chk("tx_end",    32'(tx[d]),    32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;

    // Reset behaviour and idle line.
    #3 reset = 1'b1;
    #1 chk_idle(0, "rst_imm");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle(i, "idle");
    end

    // Single 8N1 frame.
    run_frame(0, 9'h0A5, 9'h000, 1'b0, -1, -1);
    @(negedge clk);

    // 7E2 and 7O2 with the same character.
    run_frame(1, 9'h053, 9'h000, 1'b0, -1, -1);
    @(negedge clk);
    run_frame(2, 9'h053, 9'h000, 1'b0, -1, -1);
    @(negedge clk);

    // Back-to-back frames with valid held and data changed mid-frame.
    run_frame(0, 9'h000, 9'h0FF, 1'b1, -1, -1);
    run_frame(0, 9'h0FF, 9'h000, 1'b0, -1, -1);
    @(negedge clk);

    // valid pulsed while busy is ignored.
    run_frame(0, 9'($urandom), 9'h000, 1'b0, 30, -1);
    repeat (30) begin
      @(negedge clk);
      chk_idle(0, "no_extra");
    end

    // Reset during data bit 3, then a clean frame.
    run_frame(0, 9'($urandom), 9'h000, 1'b0, -1, 44);
    run_frame(0, 9'h03C, 9'h000, 1'b0, -1, -1);
    @(negedge clk);

    // Random characters on random instances with random idle gaps.
    repeat (12) begin
      d = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(d, 9'($urandom), 9'h000, 1'b0, -1, -1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
